// File: rtl/panic_dma_tx.sv
// Host-to-crossbar DMA transmit port: buffers each packet whole, then emits one
// PANIC descriptor flit followed by the payload, all tagged as bypass-path.

`ifndef PANIC_DESC_LEN_OF
`define PANIC_DESC_LEN_OF 0
`endif
`ifndef PANIC_DESC_CELL_ID_OF
`define PANIC_DESC_CELL_ID_OF 16
`endif
`ifndef PANIC_DESC_PORT_OF
`define PANIC_DESC_PORT_OF 24
`endif
`ifndef PANIC_DESC_FLOW_OF
`define PANIC_DESC_FLOW_OF 32
`endif
`ifndef PANIC_DESC_TS_OF
`define PANIC_DESC_TS_OF 64
`endif
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 32
`endif

module panic_dma_tx #(
   parameter int unsigned AXIS_DATA_WIDTH   = 512,
   parameter int unsigned AXIS_KEEP_WIDTH   = AXIS_DATA_WIDTH / 8,
   parameter int unsigned SWITCH_DATA_WIDTH = 512,
   parameter int unsigned SWITCH_KEEP_WIDTH = SWITCH_DATA_WIDTH / 8,
   parameter int unsigned SWITCH_DEST_WIDTH = 3,
   parameter int unsigned SWITCH_USER_WIDTH = 1,
   parameter int unsigned LEN_WIDTH         = 16,
   parameter int unsigned DATA_DEPTH        = 32,
   parameter int unsigned DESC_DEPTH        = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [AXIS_DATA_WIDTH-1:0]     s_tx_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]     s_tx_axis_tkeep,
   input  logic                           s_tx_axis_tvalid,
   output logic                           s_tx_axis_tready,
   input  logic                           s_tx_axis_tlast,
   input  logic [4:0]                     s_tx_flow,
   input  logic [SWITCH_DEST_WIDTH-1:0]   cfg_dest,
   output logic [SWITCH_DATA_WIDTH-1:0]   m_switch_axis_tdata,
   output logic [SWITCH_KEEP_WIDTH-1:0]   m_switch_axis_tkeep,
   output logic                           m_switch_axis_tvalid,
   input  logic                           m_switch_axis_tready,
   output logic                           m_switch_axis_tlast,
   output logic [SWITCH_DEST_WIDTH-1:0]   m_switch_axis_tdest,
   output logic [SWITCH_USER_WIDTH-1:0]   m_switch_axis_tuser,
   input  logic [`PANIC_DESC_TS_SIZE-1:0] timestamp,
   output logic [15:0]                    drop_count
);

   localparam int unsigned AW  = $clog2(DATA_DEPTH);
   localparam int unsigned PW  = AW + 1;
   localparam int unsigned DAW = $clog2(DESC_DEPTH);
   localparam int unsigned DPW = DAW + 1;
   localparam int unsigned CW  = $clog2(DATA_DEPTH + 1);
   localparam int unsigned TSW = `PANIC_DESC_TS_SIZE;

   typedef enum logic [0:0] {WrAccept, WrDrop} wr_state_e;
   typedef enum logic [1:0] {RdIdle, RdHdr, RdPayload} rd_state_e;

   function automatic logic [LEN_WIDTH-1:0] popcnt(input logic [AXIS_KEEP_WIDTH-1:0] k);
      logic [LEN_WIDTH-1:0] c;
      c = '0;
      for (int i = 0; i < int'(AXIS_KEEP_WIDTH); i++) begin
         c = c + LEN_WIDTH'(k[i]);
      end
      return c;
   endfunction

   // Storage
   logic [AXIS_DATA_WIDTH-1:0]   data_mem       [DATA_DEPTH];
   logic [AXIS_KEEP_WIDTH-1:0]   keep_mem       [DATA_DEPTH];
   logic [LEN_WIDTH-1:0]         desc_len_mem   [DESC_DEPTH];
   logic [4:0]                   desc_flow_mem  [DESC_DEPTH];
   logic [SWITCH_DEST_WIDTH-1:0] desc_dest_mem  [DESC_DEPTH];
   logic [TSW-1:0]               desc_ts_mem    [DESC_DEPTH];
   logic [CW-1:0]                desc_beats_mem [DESC_DEPTH];

   // Write side state
   wr_state_e                    wr_state_q, wr_state_d;
   logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]                wr_commit_q, wr_commit_d;
   logic [LEN_WIDTH-1:0]         len_q, len_d;
   logic [CW-1:0]                beat_cnt_q, beat_cnt_d;
   logic [4:0]                   cur_flow_q, cur_flow_d;
   logic [SWITCH_DEST_WIDTH-1:0] cur_dest_q, cur_dest_d;
   logic [TSW-1:0]               cur_ts_q, cur_ts_d;
   logic [15:0]                  drop_q, drop_d;
   logic [DPW-1:0]               desc_wr_q, desc_wr_d;

   // Read side state
   rd_state_e                    rd_state_q, rd_state_d;
   logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]                free_ptr_q, free_ptr_d;
   logic [DPW-1:0]               desc_rd_q, desc_rd_d;
   logic [DPW-1:0]               desc_hd_q, desc_hd_d;
   logic [CW-1:0]                rd_rem_q, rd_rem_d;
   logic [SWITCH_DEST_WIDTH-1:0] rd_dest_q, rd_dest_d;

   // Output register
   logic                         out_valid_q, out_valid_d;
   logic [SWITCH_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [SWITCH_KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
   logic                         out_last_q, out_last_d;
   logic [SWITCH_DEST_WIDTH-1:0] out_dest_q, out_dest_d;
   logic [SWITCH_USER_WIDTH-1:0] out_user_q, out_user_d;
   logic                         out_pay_q, out_pay_d;

   // Combinational helpers
   logic                         s_ready;
   logic                         mem_we;
   logic                         desc_we;
   logic [LEN_WIDTH-1:0]         len_sum;
   logic [CW-1:0]                beats_sum;
   logic                         first_beat;
   logic [15:0]                  drop_inc;
   logic [PW-1:0]                data_occ;
   logic [DPW-1:0]               desc_occ;
   logic                         data_full;
   logic                         desc_full;
   logic                         desc_avail;
   logic [DPW-1:0]               desc_hd_inc;
   logic [DAW-1:0]               head;
   logic                         load;
   logic                         hs;
   logic [SWITCH_DATA_WIDTH-1:0] hdr;

   // Space is reclaimed only when payload leaves the port, so fetched-but-unsent
   // flits still count as occupied.
   assign data_occ   = wr_ptr_q - free_ptr_q;
   assign desc_occ   = desc_wr_q - desc_rd_q;
   assign data_full  = (data_occ == PW'(DATA_DEPTH));
   assign desc_full  = (desc_occ == DPW'(DESC_DEPTH));
   assign desc_avail = (desc_hd_q != desc_wr_q);
   assign drop_inc   = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

   always_comb begin
      wr_state_d = wr_state_q;
      wr_ptr_d   = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      cur_flow_d = cur_flow_q;
      cur_dest_d = cur_dest_q;
      cur_ts_d   = cur_ts_q;
      drop_d     = drop_q;
      desc_wr_d  = desc_wr_q;
      mem_we     = 1'b0;
      desc_we    = 1'b0;
      s_ready    = 1'b0;
      first_beat = (beat_cnt_q == '0);
      len_sum    = len_q + popcnt(s_tx_axis_tkeep);
      beats_sum  = beat_cnt_q + 1'b1;
      unique case (wr_state_q)
         WrAccept: begin
            s_ready = !data_full && !desc_full;
            if (s_tx_axis_tvalid && s_ready) begin
               mem_we = 1'b1;
               if (first_beat) begin
                  cur_flow_d = s_tx_flow;
                  cur_dest_d = cfg_dest;
                  cur_ts_d   = timestamp;
               end
               if (s_tx_axis_tlast) begin
                  len_d      = '0;
                  beat_cnt_d = '0;
                  if (len_sum == '0) begin
                     wr_ptr_d = wr_commit_q;
                     drop_d   = drop_inc;
                  end else begin
                     desc_we     = 1'b1;
                     desc_wr_d   = desc_wr_q + 1'b1;
                     wr_ptr_d    = wr_ptr_q + 1'b1;
                     wr_commit_d = wr_ptr_q + 1'b1;
                  end
               end else if (beats_sum == CW'(DATA_DEPTH)) begin
                  // Cannot fit: discard what was written and swallow the rest.
                  len_d      = '0;
                  beat_cnt_d = '0;
                  wr_ptr_d   = wr_commit_q;
                  drop_d     = drop_inc;
                  wr_state_d = WrDrop;
               end else begin
                  len_d      = len_sum;
                  beat_cnt_d = beats_sum;
                  wr_ptr_d   = wr_ptr_q + 1'b1;
               end
            end
         end
         WrDrop: begin
            s_ready = 1'b1;
            if (s_tx_axis_tvalid && s_tx_axis_tlast) begin
               wr_state_d = WrAccept;
            end
         end
         default: wr_state_d = WrAccept;
      endcase
   end

   assign s_tx_axis_tready = s_ready & ~rst;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         data_mem[wr_ptr_q[AW-1:0]] <= s_tx_axis_tdata;
         keep_mem[wr_ptr_q[AW-1:0]] <= s_tx_axis_tkeep;
      end
      if (desc_we) begin
         desc_len_mem[desc_wr_q[DAW-1:0]]   <= len_sum;
         desc_flow_mem[desc_wr_q[DAW-1:0]]  <= first_beat ? s_tx_flow : cur_flow_q;
         desc_dest_mem[desc_wr_q[DAW-1:0]]  <= first_beat ? cfg_dest : cur_dest_q;
         desc_ts_mem[desc_wr_q[DAW-1:0]]    <= first_beat ? timestamp : cur_ts_q;
         desc_beats_mem[desc_wr_q[DAW-1:0]] <= beats_sum;
      end
   end

   assign head        = desc_hd_q[DAW-1:0];
   assign desc_hd_inc = desc_hd_q + 1'b1;
   assign load        = !out_valid_q || m_switch_axis_tready;
   assign hs          = out_valid_q && m_switch_axis_tready;

   always_comb begin
      hdr = '0;
      hdr[`PANIC_DESC_LEN_OF +: LEN_WIDTH] = desc_len_mem[head];
      hdr[`PANIC_DESC_FLOW_OF +: 5]        = desc_flow_mem[head];
      hdr[`PANIC_DESC_TS_OF +: TSW]        = desc_ts_mem[head];
   end

   // The header head pointer runs ahead of the pop pointer so the next header can
   // be loaded in the same cycle the previous packet's last flit is handshaken.
   always_comb begin
      rd_state_d  = rd_state_q;
      rd_ptr_d    = rd_ptr_q;
      free_ptr_d  = free_ptr_q;
      desc_rd_d   = desc_rd_q;
      desc_hd_d   = desc_hd_q;
      rd_rem_d    = rd_rem_q;
      rd_dest_d   = rd_dest_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_dest_d  = out_dest_q;
      out_user_d  = out_user_q;
      out_pay_d   = out_pay_q;
      if (hs) begin
         out_valid_d = 1'b0;
         if (out_pay_q) begin
            free_ptr_d = free_ptr_q + 1'b1;
            if (out_last_q) begin
               desc_rd_d = desc_rd_q + 1'b1;
            end
         end
      end
      unique case (rd_state_q)
         RdIdle: begin
            if (desc_avail) begin
               rd_state_d = RdHdr;
            end
         end
         RdHdr: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = hdr;
               out_keep_d  = '1;
               out_last_d  = 1'b0;
               out_dest_d  = desc_dest_mem[head];
               out_user_d  = SWITCH_USER_WIDTH'(1);
               out_pay_d   = 1'b0;
               rd_dest_d   = desc_dest_mem[head];
               rd_rem_d    = desc_beats_mem[head];
               rd_state_d  = RdPayload;
            end
         end
         RdPayload: begin
            if (load && (rd_ptr_q != wr_commit_q)) begin
               out_valid_d = 1'b1;
               out_data_d  = data_mem[rd_ptr_q[AW-1:0]];
               out_keep_d  = keep_mem[rd_ptr_q[AW-1:0]];
               out_last_d  = (rd_rem_q == CW'(1));
               out_dest_d  = rd_dest_q;
               out_user_d  = SWITCH_USER_WIDTH'(1);
               out_pay_d   = 1'b1;
               rd_ptr_d    = rd_ptr_q + 1'b1;
               rd_rem_d    = rd_rem_q - 1'b1;
               if (rd_rem_q == CW'(1)) begin
                  desc_hd_d  = desc_hd_inc;
                  rd_state_d = (desc_hd_inc != desc_wr_q) ? RdHdr : RdIdle;
               end
            end
         end
         default: rd_state_d = RdIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q  <= WrAccept;
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         cur_flow_q  <= '0;
         cur_dest_q  <= '0;
         cur_ts_q    <= '0;
         drop_q      <= '0;
         desc_wr_q   <= '0;
         rd_state_q  <= RdIdle;
         rd_ptr_q    <= '0;
         free_ptr_q  <= '0;
         desc_rd_q   <= '0;
         desc_hd_q   <= '0;
         rd_rem_q    <= '0;
         rd_dest_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_dest_q  <= '0;
         out_user_q  <= '0;
         out_pay_q   <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         cur_flow_q  <= cur_flow_d;
         cur_dest_q  <= cur_dest_d;
         cur_ts_q    <= cur_ts_d;
         drop_q      <= drop_d;
         desc_wr_q   <= desc_wr_d;
         rd_state_q  <= rd_state_d;
         rd_ptr_q    <= rd_ptr_d;
         free_ptr_q  <= free_ptr_d;
         desc_rd_q   <= desc_rd_d;
         desc_hd_q   <= desc_hd_d;
         rd_rem_q    <= rd_rem_d;
         rd_dest_q   <= rd_dest_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_dest_q  <= out_dest_d;
         out_user_q  <= out_user_d;
         out_pay_q   <= out_pay_d;
      end
   end

   assign m_switch_axis_tvalid = out_valid_q;
   assign m_switch_axis_tdata  = out_data_q;
   assign m_switch_axis_tkeep  = out_keep_q;
   assign m_switch_axis_tlast  = out_last_q;
   assign m_switch_axis_tdest  = out_dest_q;
   assign m_switch_axis_tuser  = out_user_q;
   assign drop_count           = drop_q;

endmodule

// File: tb/tb_panic_dma_tx.sv
// Scoreboard bench for panic_dma_tx: expected flits are queued as packets are
// driven and compared against every valid output cycle, including held ones.

`ifndef PANIC_DESC_LEN_OF
`define PANIC_DESC_LEN_OF 0
`endif
`ifndef PANIC_DESC_FLOW_OF
`define PANIC_DESC_FLOW_OF 32
`endif
`ifndef PANIC_DESC_TS_OF
`define PANIC_DESC_TS_OF 64
`endif
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 32
`endif

module tb_panic_dma_tx;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
      logic [2:0]   dest;
      logic         user;
   } flit_t;

   logic         clk;
   logic         rst;
   logic [511:0] s_tdata;
   logic [63:0]  s_tkeep;
   logic         s_tvalid;
   logic         s_tready;
   logic         s_tlast;
   logic [4:0]   s_flow;
   logic [2:0]   cfg_dest;
   logic [511:0] m_tdata;
   logic [63:0]  m_tkeep;
   logic         m_tvalid;
   logic         m_tready;
   logic         m_tlast;
   logic [2:0]   m_tdest;
   logic [0:0]   m_tuser;
   logic [`PANIC_DESC_TS_SIZE-1:0] timestamp;
   logic [15:0]  drop_count;

   int    checks = 0;
   int    errors = 0;
   int    ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
   flit_t exp_q[$];

   panic_dma_tx dut (
      .clk                  (clk),
      .rst                  (rst),
      .s_tx_axis_tdata      (s_tdata),
      .s_tx_axis_tkeep      (s_tkeep),
      .s_tx_axis_tvalid     (s_tvalid),
      .s_tx_axis_tready     (s_tready),
      .s_tx_axis_tlast      (s_tlast),
      .s_tx_flow            (s_flow),
      .cfg_dest             (cfg_dest),
      .m_switch_axis_tdata  (m_tdata),
      .m_switch_axis_tkeep  (m_tkeep),
      .m_switch_axis_tvalid (m_tvalid),
      .m_switch_axis_tready (m_tready),
      .m_switch_axis_tlast  (m_tlast),
      .m_switch_axis_tdest  (m_tdest),
      .m_switch_axis_tuser  (m_tuser),
      .timestamp            (timestamp),
      .drop_count           (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] mk_hdr(input logic [15:0] len, input logic [4:0] flow,
                                           input logic [31:0] ts);
      logic [511:0] h;
      h = '0;
      h[`PANIC_DESC_LEN_OF +: 16]  = len;
      h[`PANIC_DESC_FLOW_OF +: 5]  = flow;
      h[`PANIC_DESC_TS_OF +: 32]   = ts;
      return h;
   endfunction

   function automatic logic [63:0] keep_for(input int bytes);
      logic [63:0] m;
      m = '1;
      if (bytes <= 0) return '0;
      return m >> (64 - bytes);
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Sink ready driver
   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Every valid cycle must present the head of the scoreboard; pop on handshake.
   always @(negedge clk) begin
      if (!rst && m_tvalid) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_flit", 512'(m_tvalid), 512'(0));
         end else begin
            check_eq("out_data", m_tdata, exp_q[0].data);
            check_eq("out_ctl", 512'({m_tkeep, m_tlast, m_tdest, m_tuser}),
                     512'({exp_q[0].keep, exp_q[0].last, exp_q[0].dest, exp_q[0].user}));
            if (m_tready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
      int  n;
      bit  ok;
      n = 0;
      ok = 0;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tvalid = 1'b1;
      while (!ok) begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
         n++;
         if (!ok && n > 5000) begin
            check_eq("in_accept_timeout", 512'(1), 512'(0));
            ok = 1;
         end
      end
   endtask

   task automatic send_pkt(input int nbeats, input int last_bytes, input logic [4:0] flow,
                           input logic [2:0] dest, input logic [31:0] ts, input bit good);
      logic [511:0] beat_data[64];
      logic [63:0]  k;
      logic [15:0]  len;
      flit_t        f;
      len = 16'((nbeats - 1) * 64 + last_bytes);
      for (int b = 0; b < nbeats; b++) beat_data[b] = rand512();
      if (good) begin
         f.data = mk_hdr(len, flow, ts);
         f.keep = '1;
         f.last = 1'b0;
         f.dest = dest;
         f.user = 1'b1;
         exp_q.push_back(f);
         for (int b = 0; b < nbeats; b++) begin
            f.data = beat_data[b];
            f.keep = (b == nbeats - 1) ? keep_for(last_bytes) : '1;
            f.last = (b == nbeats - 1);
            exp_q.push_back(f);
         end
      end
      @(posedge clk);
      #1;
      for (int b = 0; b < nbeats; b++) begin
         if (b == 0) begin
            s_flow    = flow;
            cfg_dest  = dest;
            timestamp = ts;
         end else begin
            // Later-beat sideband must be ignored
            s_flow    = ~flow;
            cfg_dest  = ~dest;
            timestamp = ~ts;
         end
         k = (b == nbeats - 1) ? keep_for(last_bytes) : '1;
         drive_beat(beat_data[b], k, (b == nbeats - 1));
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // Called right after a tlast handshake: checks header latency and no bubbles.
   task automatic burst_shape(input string tag, input int nflits);
      for (int i = 0; i < nflits + 3; i++) begin
         @(negedge clk);
         check_eq(tag, 512'(m_tvalid), 512'((i >= 2) && (i < 2 + nflits)));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      check_eq("drain_left", 512'(exp_q.size()), 512'(0));
   endtask

   task automatic do_reset();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_tvalid", 512'(m_tvalid), 512'(0));
      check_eq("rst_tdata", m_tdata, 512'(0));
      check_eq("rst_ctl", 512'({m_tkeep, m_tlast, m_tdest, m_tuser}), 512'(0));
      check_eq("rst_s_tready", 512'(s_tready), 512'(0));
      check_eq("rst_drop_count", 512'(drop_count), 512'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      s_tdata   = '0;
      s_tkeep   = '0;
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      s_flow    = '0;
      cfg_dest  = '0;
      timestamp = '0;
      rst       = 1'b1;
      do_reset();
      repeat (3) @(posedge clk);

      // One-beat packet, header latency and shape
      send_pkt(1, 64, 5'd3, 3'd2, 32'd100, 1);
      burst_shape("t1_shape", 2);
      drain();

      // Three-beat packet with short last beat: LEN=132, four flits back to back
      send_pkt(3, 4, 5'd5, 3'd6, 32'd200, 1);
      burst_shape("t2_shape", 4);
      drain();

      // Random backpressure over 20 packets
      ready_mode = 2;
      for (int p = 0; p < 20; p++) begin
         send_pkt($urandom_range(1, 4), $urandom_range(1, 64), 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), $urandom(), 1);
      end
      ready_mode = 1;
      drain();

      // Descriptor FIFO fills at four pending packets
      ready_mode = 0;
      repeat (2) @(posedge clk);
      for (int p = 0; p < 4; p++) begin
         send_pkt(1, 64, 5'(p + 1), 3'(p), 32'(1000 + p), 1);
      end
      @(negedge clk);
      check_eq("t4_s_tready_full", 512'(s_tready), 512'(0));
      ready_mode = 1;
      send_pkt(1, 64, 5'd9, 3'd7, 32'd1004, 1);
      drain();

      // Oversize packet dropped, following packet intact
      send_pkt(33, 64, 5'd1, 3'd1, 32'd3000, 0);
      send_pkt(2, 64, 5'd2, 3'd4, 32'd3001, 1);
      drain();
      check_eq("t5_drop_count", 512'(drop_count), 512'(1));

      // Zero-length packet dropped
      send_pkt(1, 0, 5'd4, 3'd3, 32'd4000, 0);
      repeat (5) @(posedge clk);
      check_eq("zero_len_drop_count", 512'(drop_count), 512'(2));
      drain();

      // Reset in the middle of a packet
      @(posedge clk);
      #1;
      s_flow    = 5'd6;
      cfg_dest  = 3'd5;
      timestamp = 32'd5000;
      drive_beat(rand512(), '1, 1'b0);
      drive_beat(rand512(), '1, 1'b0);
      do_reset();
      repeat (10) @(posedge clk);
      check_eq("t6_no_output", 512'(m_tvalid), 512'(0));
      send_pkt(2, 10, 5'd7, 3'd3, 32'd6000, 1);
      drain();
      check_eq("t6_drop_count", 512'(drop_count), 512'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
